// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : mc_controller_if
// Purpose   : Memory handshake bundle between the multi-cycle control unit and
//             the instruction/data memories.
// Signals   : imem_req/imem_ack/imem_rdata - instruction fetch handshake
//             dmem_req/dmem_we/dmem_ack    - data access handshake
// Modports  : master - control unit side (drives requests)
//             slave  - memory side (drives acks and fetched instruction)
// Revision  : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module    : mc_controller
// Purpose   : Multi-cycle control unit for the 31-instruction MIPS core.
//             Latches the fetched instruction into IR and steps
//             FETCH/DECODE/EXEC/MEM/WB with memory wait-state handshakes,
//             an ack watchdog and a sticky fault state.
// Ports     : clk, rst (async, active high), run (start from IDLE)
//             mem        - memory handshake interface (master side)
//             alu_zero   - ALU zero flag for beq/bne
//             aluc, is_shamt, is_signed, rs, rt, rd, rf_datatype - IR decode
//             rf_wena, pc_we, jump_type - write-back / PC update controls
//             md_start, md_done - multiply/divide handshake
//             busy, fault, fault_code - status
// Options   : MULDIV_EN - when defined, mult/multu/div/divu and mfhi/mflo are
//             legal; otherwise they raise an illegal-instruction fault.
// Revision  : 1.0 - initial release
// ============================================================================
module mc_controller #(
    parameter int WDOG_W   = 4,
    parameter int LINK_REG = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    mc_controller_if.master       mem,
    input  logic                  alu_zero,
    output logic [3:0]            aluc,
    output logic                  is_shamt,
    output logic                  is_signed,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic                  rf_wena,
    output logic [2:0]            rf_datatype,
    output logic [4:0]            jump_type,
    output logic                  pc_we,
    output logic                  md_start,
    input  logic                  md_done,
    output logic                  busy,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    localparam logic [4:0]        LINK_ADDR = 5'(LINK_REG);
    // Last waiting cycle before timeout: the count starts at 0 on entry, so
    // the (2**WDOG_W-1)-th waiting cycle holds count 2**WDOG_W-2.
    localparam logic [WDOG_W-1:0] WD_LAST   = WDOG_W'((1 << WDOG_W) - 2);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_FAULT  = 4'd6,
        S_MDWAIT = 4'd7,
        S_RETIRE = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_ALU = 3'd0, C_LW = 3'd1, C_SW = 3'd2, C_BR = 3'd3,
        C_JMP = 3'd4, C_JAL = 3'd5, C_MD = 3'd6
    } cls_t;

    state_t              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [1:0]          code_q, code_d;

    logic [5:0]          w_op, w_fn;
    logic                w_legal;
    cls_t                w_cls;
    logic                w_md_start;

    assign w_op = ir_q[31:26];
    assign w_fn = ir_q[5:0];

    // ------------------------------------------------------------------
    // Instruction decode (pure function of IR, plus alu_zero for branches)
    // ------------------------------------------------------------------
    always_comb begin
        aluc      = 4'b0000;
        is_shamt  = 1'b0;
        is_signed = 1'b0;
        w_legal   = 1'b0;
        w_cls     = C_ALU;
        jump_type = 5'b10000;
        case (w_op)
            6'b000000: begin
                w_legal = 1'b1;
                case (w_fn)
                    6'b100000: aluc = 4'b0010;                       // add
                    6'b100001: aluc = 4'b0000;                       // addu
                    6'b100010: aluc = 4'b0011;                       // sub
                    6'b100011: aluc = 4'b0001;                       // subu
                    6'b100100: aluc = 4'b0100;                       // and
                    6'b100101: aluc = 4'b0101;                       // or
                    6'b100110: aluc = 4'b0110;                       // xor
                    6'b100111: aluc = 4'b0111;                       // nor
                    6'b101010: aluc = 4'b1011;                       // slt
                    6'b101011: aluc = 4'b1010;                       // sltu
                    6'b000000: begin aluc = 4'b1110; is_shamt = 1'b1; end // sll
                    6'b000010: begin aluc = 4'b1101; is_shamt = 1'b1; end // srl
                    6'b000011: begin aluc = 4'b1100; is_shamt = 1'b1; end // sra
                    6'b000100: aluc = 4'b1110;                       // sllv
                    6'b000110: aluc = 4'b1101;                       // srlv
                    6'b000111: aluc = 4'b1100;                       // srav
                    6'b001000: begin w_cls = C_JMP; jump_type = 5'b00010; end // jr
`ifdef MULDIV_EN
                    6'b010000, 6'b010010: aluc = 4'b0000;            // mfhi/mflo
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: w_cls = C_MD;              // mult/div
`endif
                    default:   w_legal = 1'b0;
                endcase
            end
            6'b001000: begin w_legal = 1'b1; aluc = 4'b0010; is_signed = 1'b1; end // addi
            6'b001001: begin w_legal = 1'b1; aluc = 4'b0000; is_signed = 1'b1; end // addiu
            6'b001010: begin w_legal = 1'b1; aluc = 4'b1011; is_signed = 1'b1; end // slti
            6'b001011: begin w_legal = 1'b1; aluc = 4'b1010; is_signed = 1'b1; end // sltiu
            6'b001100: begin w_legal = 1'b1; aluc = 4'b0100; end                   // andi
            6'b001101: begin w_legal = 1'b1; aluc = 4'b0101; end                   // ori
            6'b001110: begin w_legal = 1'b1; aluc = 4'b0110; end                   // xori
            6'b001111: begin w_legal = 1'b1; aluc = 4'b1000; end                   // lui
            6'b100011: begin w_legal = 1'b1; w_cls = C_LW; end                     // lw
            6'b101011: begin w_legal = 1'b1; w_cls = C_SW; end                     // sw
            6'b000100: begin                                                       // beq
                w_legal = 1'b1; w_cls = C_BR; aluc = 4'b0001;
                if (alu_zero) jump_type = 5'b01000;
            end
            6'b000101: begin                                                       // bne
                w_legal = 1'b1; w_cls = C_BR; aluc = 4'b0001;
                if (!alu_zero) jump_type = 5'b00100;
            end
            6'b000010: begin w_legal = 1'b1; w_cls = C_JMP; jump_type = 5'b00001; end // j
            6'b000011: begin w_legal = 1'b1; w_cls = C_JAL; jump_type = 5'b00001; end // jal
            default:   w_legal = 1'b0;
        endcase
        // The all-zero word is the canonical nop; present it with neutral
        // ALU controls so the reset/idle decode is all zeros.
        if (ir_q == 32'h0000_0000) begin
            aluc     = 4'b0000;
            is_shamt = 1'b0;
        end
    end

    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = (w_cls == C_JAL) ? LINK_ADDR :
                         (w_op != 6'b000000) ? ir_q[20:16] : ir_q[15:11];
    assign rf_datatype = (w_cls == C_LW)  ? 3'b100 :
                         (w_cls == C_JAL) ? 3'b010 : 3'b001;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wdog_q  <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wdog_q  <= wdog_d;
            code_q  <= code_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. The watchdog count defaults to 0 so that it
    // is cleared on every entry into FETCH/MEM and only advances while a
    // request is waiting for its ack.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        wdog_d       = '0;
        code_d       = code_q;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        rf_wena      = 1'b0;
        pc_we        = 1'b0;
        w_md_start   = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    state_d = S_DECODE;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end else begin
                    wdog_d  = wdog_q + WDOG_W'(1);
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end
            end
            S_EXEC: begin
                case (w_cls)
                    C_LW, C_SW:    state_d = S_MEM;
                    C_BR, C_JMP: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
`ifdef MULDIV_EN
                    C_MD: begin
                        w_md_start = 1'b1;
                        state_d    = S_MDWAIT;
                    end
`endif
                    default:       state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (w_cls == C_SW);
                if (mem.dmem_ack) begin
                    if (w_cls == C_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'b11;
                end else begin
                    wdog_d  = wdog_q + WDOG_W'(1);
                end
            end
            S_WB: begin
                rf_wena = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MULDIV_EN
            // Multiply/divide has no watchdog: its latency is bounded by the unit.
            S_MDWAIT: if (md_done) state_d = S_RETIRE;
            S_RETIRE: begin
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
`endif
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULDIV_EN
    assign md_start = w_md_start;
`else
    logic unused_md;
    assign md_start  = 1'b0;
    assign unused_md = md_done ^ w_md_start;
`endif

    assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;

endmodule
`default_nettype wire
